mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-bus loads/stores with lane alignment and extension,
// registered writeback toward WB, and an upstream stall while an access is outstanding.
module mem_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RF_AW  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              ex_reg_wen,
   input  logic [RF_AW-1:0]  ex_reg_waddr,
   input  logic [DATA_W-1:0] ex_alu_out,
   input  logic              ex_ill_instr,
   input  logic              ex_mem_rd,
   input  logic              ex_mem_wr,
   input  logic [1:0]        ex_mem_size,
   input  logic              ex_mem_unsigned,
   input  logic [DATA_W-1:0] ex_store_data,
   output logic              mem_stall,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [DATA_W-1:0] dbus_addr,
   output logic [DATA_W-1:0] dbus_wdata,
   output logic [3:0]        dbus_be,
   input  logic              dbus_ready,
   input  logic              dbus_rvalid,
   input  logic [DATA_W-1:0] dbus_rdata,
   output logic              mem_reg_wen,
   output logic [RF_AW-1:0]  mem_reg_waddr,
   output logic [DATA_W-1:0] mem_reg_wdata,
   output logic              mem_ill_instr,
   output logic              mem_misalign
);

   typedef enum logic [0:0] {StIdle, StWaitRd} state_e;

   state_e state_q, state_d;

   logic              wen_q, wen_d;
   logic [RF_AW-1:0]  waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ill_q, ill_d;
   logic              mis_q, mis_d;

   logic [1:0]        addr_lo;
   logic              is_byte, is_half, is_word;
   logic              misal, ls_op, mem_op;
   logic [DATA_W-1:0] lane;
   logic [DATA_W-1:0] load_data;

   assign addr_lo = ex_alu_out[1:0];
   assign is_byte = (ex_mem_size == 2'b00);
   assign is_half = (ex_mem_size == 2'b01);
   // Size 2'b11 falls into the word case.
   assign is_word = ex_mem_size[1];
   assign misal   = (is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00));
   assign ls_op   = ex_valid & (ex_mem_rd | ex_mem_wr);
   assign mem_op  = ls_op & ~ex_ill_instr & ~misal;

   assign dbus_we   = ex_mem_wr;
   assign dbus_addr = {ex_alu_out[DATA_W-1:2], 2'b00};

   always_comb begin
      dbus_be    = 4'b1111;
      dbus_wdata = ex_store_data;
      if (is_byte) begin
         dbus_be    = 4'b0001 << addr_lo;
         dbus_wdata = {4{ex_store_data[7:0]}};
      end else if (is_half) begin
         dbus_be    = 4'b0011 << {addr_lo[1], 1'b0};
         dbus_wdata = {2{ex_store_data[15:0]}};
      end
   end

   assign lane = dbus_rdata >> {addr_lo, 3'b000};

   always_comb begin
      load_data = lane;
      if (is_byte) begin
         load_data = {{24{~ex_mem_unsigned & lane[7]}}, lane[7:0]};
      end else if (is_half) begin
         load_data = {{16{~ex_mem_unsigned & lane[15]}}, lane[15:0]};
      end
   end

   always_comb begin
      state_d   = state_q;
      dbus_req  = 1'b0;
      mem_stall = 1'b0;
      case (state_q)
         StIdle: begin
            dbus_req = mem_op;
            // Loads always stall here; stores only until the bus accepts them.
            mem_stall = mem_op & (ex_mem_rd | ~dbus_ready);
            if (mem_op & ex_mem_rd & dbus_ready) begin
               state_d = StWaitRd;
            end
         end
         StWaitRd: begin
            mem_stall = ~dbus_rvalid;
            if (dbus_rvalid) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      ill_d   = 1'b0;
      mis_d   = 1'b0;
      if (mem_stall) begin
         // Bubble: defaults already clear the valid-type flags.
      end else if (state_q == StWaitRd) begin
         wen_d   = ex_reg_wen;
         waddr_d = ex_reg_waddr;
         wdata_d = load_data;
      end else if (ex_valid & ex_ill_instr) begin
         ill_d = 1'b1;
      end else if (ls_op & misal) begin
         mis_d = 1'b1;
      end else if (!mem_op) begin
         wen_d   = ex_valid & ex_reg_wen;
         waddr_d = ex_reg_waddr;
         wdata_d = ex_alu_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         ill_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         ill_q   <= ill_d;
         mis_q   <= mis_d;
      end
   end

   assign mem_reg_wen   = wen_q;
   assign mem_reg_waddr = waddr_q;
   assign mem_reg_wdata = wdata_q;
   assign mem_ill_instr = ill_q;
   assign mem_misalign  = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inline bus/stall checks plus a cycle-stamped
// writeback scoreboard drained by an independent monitor.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_reg_wen, ex_ill_instr, ex_mem_rd, ex_mem_wr, ex_mem_unsigned;
   logic [4:0]  ex_reg_waddr;
   logic [31:0] ex_alu_out, ex_store_data;
   logic [1:0]  ex_mem_size;
   logic        mem_stall, dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]  dbus_be;
   logic        dbus_ready, dbus_rvalid;
   logic        mem_reg_wen, mem_ill_instr, mem_misalign;
   logic [4:0]  mem_reg_waddr;
   logic [31:0] mem_reg_wdata;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_reg_wen(ex_reg_wen), .ex_reg_waddr(ex_reg_waddr),
      .ex_alu_out(ex_alu_out), .ex_ill_instr(ex_ill_instr), .ex_mem_rd(ex_mem_rd),
      .ex_mem_wr(ex_mem_wr), .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
      .ex_store_data(ex_store_data), .mem_stall(mem_stall), .dbus_req(dbus_req),
      .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
      .dbus_ready(dbus_ready), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
      .mem_reg_wen(mem_reg_wen), .mem_reg_waddr(mem_reg_waddr),
      .mem_reg_wdata(mem_reg_wdata), .mem_ill_instr(mem_ill_instr),
      .mem_misalign(mem_misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        ill;
      logic        mis;
   } wb_t;

   wb_t sb_q[$];
   int  cyc = 0;
   int  tests = 0;
   int  failed = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected writeback appears right after the next rising edge.
   task automatic push_wb(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                          input logic ill, input logic mis);
      wb_t e;
      e.cyc = cyc + 1; e.wen = wen; e.waddr = waddr; e.wdata = wdata; e.ill = ill; e.mis = mis;
      sb_q.push_back(e);
   endtask

   initial begin : monitor
      wb_t e;
      forever begin
         @(posedge clk);
         #1;
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            tests++; failed++;
            $display("FAIL wb_missing: got nothing, want writeback due at cycle %0d", e.cyc);
         end
         if (mem_reg_wen || mem_ill_instr || mem_misalign) begin
            if (sb_q.size() == 0 || sb_q[0].cyc != cyc) begin
               tests++; failed++;
               $display("FAIL wb_unexpected: got wen=%b ill=%b mis=%b wdata=%h, want none (cycle %0d)",
                        mem_reg_wen, mem_ill_instr, mem_misalign, mem_reg_wdata, cyc);
            end else begin
               e = sb_q.pop_front();
               chk("wb_wen", 32'(mem_reg_wen), 32'(e.wen));
               chk("wb_ill", 32'(mem_ill_instr), 32'(e.ill));
               chk("wb_mis", 32'(mem_misalign), 32'(e.mis));
               if (e.wen) begin
                  chk("wb_waddr", 32'(mem_reg_waddr), 32'(e.waddr));
                  chk("wb_wdata", mem_reg_wdata, e.wdata);
               end
            end
         end
      end
   end

   task automatic ex_idle();
      ex_valid = 0; ex_reg_wen = 0; ex_reg_waddr = '0; ex_alu_out = '0; ex_ill_instr = 0;
      ex_mem_rd = 0; ex_mem_wr = 0; ex_mem_size = 2'b10; ex_mem_unsigned = 0;
      ex_store_data = '0;
   endtask

   task automatic ex_set(input logic wen, input logic [4:0] wa, input logic [31:0] alu,
                         input logic ill, input logic rd, input logic wr,
                         input logic [1:0] size, input logic uns, input logic [31:0] sd);
      ex_valid = 1; ex_reg_wen = wen; ex_reg_waddr = wa; ex_alu_out = alu; ex_ill_instr = ill;
      ex_mem_rd = rd; ex_mem_wr = wr; ex_mem_size = size; ex_mem_unsigned = uns;
      ex_store_data = sd;
   endtask

   // Load accepted at once, rvalid after wait_cyc idle cycles in WAIT_RD.
   // Leaves ex_* holding the load at the negedge following rvalid.
   task automatic do_load(input string nm, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [4:0] wa, input int wait_cyc,
                          input logic [31:0] rdata, input logic [31:0] exp);
      ex_set(1, wa, addr, 0, 1, 0, size, uns, 32'h0);
      dbus_ready = 1;
      #1;
      chk({nm, "_req"}, 32'(dbus_req), 32'd1);
      chk({nm, "_we"}, 32'(dbus_we), 32'd0);
      chk({nm, "_stall_acc"}, 32'(mem_stall), 32'd1);
      @(negedge clk);
      dbus_ready = 0;
      for (int i = 0; i < wait_cyc; i++) begin
         #1;
         chk({nm, "_stall_wait"}, 32'(mem_stall), 32'd1);
         chk({nm, "_req_wait"}, 32'(dbus_req), 32'd0);
         @(negedge clk);
      end
      dbus_rvalid = 1;
      dbus_rdata  = rdata;
      push_wb(1, wa, exp, 0, 0);
      #1;
      chk({nm, "_stall_rv"}, 32'(mem_stall), 32'd0);
      @(negedge clk);
      dbus_rvalid = 0;
   endtask

   initial begin : stim
      rst_n = 0;
      ex_idle();
      dbus_ready = 0; dbus_rvalid = 0; dbus_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_wen", 32'(mem_reg_wen), 32'd0);
      chk("rst_wdata", mem_reg_wdata, 32'd0);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      chk("rst_req", 32'(dbus_req), 32'd0);
      rst_n = 1;
      @(negedge clk);

      // 1: ALU op
      ex_set(1, 5'd5, 32'h1234, 0, 0, 0, 2'b10, 0, 32'h0);
      push_wb(1, 5'd5, 32'h1234, 0, 0);
      #1;
      chk("alu_stall", 32'(mem_stall), 32'd0);
      chk("alu_req", 32'(dbus_req), 32'd0);
      @(negedge clk);
      ex_idle();
      @(negedge clk);

      // 2: byte store at 0x103, accepted on third cycle
      ex_set(0, 5'd0, 32'h103, 0, 0, 1, 2'b00, 0, 32'h0000_00AB);
      for (int i = 0; i < 3; i++) begin
         dbus_ready = (i == 2);
         #1;
         chk("st_req", 32'(dbus_req), 32'd1);
         chk("st_we", 32'(dbus_we), 32'd1);
         chk("st_be", 32'(dbus_be), 32'b1000);
         chk("st_wdata", dbus_wdata, 32'hABAB_ABAB);
         chk("st_addr", dbus_addr, 32'h100);
         chk("st_stall", 32'(mem_stall), (i < 2) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      dbus_ready = 0;
      ex_idle();
      @(negedge clk);

      // 3: half loads at 0x102, signed then unsigned
      ex_set(1, 5'd7, 32'h102, 0, 1, 0, 2'b01, 0, 32'h0);
      #1;
      chk("ldh_be", 32'(dbus_be), 32'b1100);
      chk("ldh_addr", dbus_addr, 32'h100);
      do_load("ldh_s", 32'h102, 2'b01, 0, 5'd7, 2, 32'h8001_FFFF, 32'hFFFF_8001);
      ex_idle();
      @(negedge clk);
      do_load("ldh_u", 32'h102, 2'b01, 1, 5'd7, 2, 32'h8001_FFFF, 32'h0000_8001);
      ex_idle();
      @(negedge clk);

      // 4: misaligned word load, then illegal instruction carrying mem_rd
      ex_set(1, 5'd3, 32'h101, 0, 1, 0, 2'b10, 0, 32'h0);
      push_wb(0, 5'd0, 32'h0, 0, 1);
      #1;
      chk("mis_req", 32'(dbus_req), 32'd0);
      chk("mis_stall", 32'(mem_stall), 32'd0);
      @(negedge clk);
      ex_idle();
      @(negedge clk);
      ex_set(1, 5'd4, 32'h200, 1, 1, 0, 2'b10, 0, 32'h0);
      push_wb(0, 5'd0, 32'h0, 1, 0);
      #1;
      chk("ill_req", 32'(dbus_req), 32'd0);
      chk("ill_stall", 32'(mem_stall), 32'd0);
      @(negedge clk);
      ex_idle();
      @(negedge clk);

      // 5: reset while in WAIT_RD, then a stray rvalid
      ex_set(1, 5'd8, 32'h200, 0, 1, 0, 2'b10, 0, 32'h0);
      dbus_ready = 1;
      @(negedge clk);
      dbus_ready = 0;
      #1;
      chk("wrd_stall", 32'(mem_stall), 32'd1);
      #1;
      rst_n = 0;
      ex_idle();
      #1;
      chk("mrst_stall", 32'(mem_stall), 32'd0);
      chk("mrst_wen", 32'(mem_reg_wen), 32'd0);
      chk("mrst_waddr", 32'(mem_reg_waddr), 32'd0);
      chk("mrst_wdata", mem_reg_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1;
      dbus_rvalid = 1;
      dbus_rdata  = 32'hFFFF_FFFF;
      #1;
      chk("stray_stall", 32'(mem_stall), 32'd0);
      chk("stray_req", 32'(dbus_req), 32'd0);
      @(negedge clk);
      dbus_rvalid = 0;
      @(negedge clk);

      // 6: signed byte load then ALU op back to back, plus unsigned byte
      do_load("ldb_s", 32'h301, 2'b00, 0, 5'd9, 0, 32'h0000_8000, 32'hFFFF_FF80);
      ex_set(1, 5'd10, 32'h55, 0, 0, 0, 2'b10, 0, 32'h0);
      push_wb(1, 5'd10, 32'h55, 0, 0);
      #1;
      chk("b2b_stall", 32'(mem_stall), 32'd0);
      @(negedge clk);
      do_load("ldb_u", 32'h301, 2'b00, 1, 5'd11, 1, 32'h0000_8000, 32'h0000_0080);
      ex_idle();
      repeat (3) @(negedge clk);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
